// File: rtl/axi_read_burst_master.sv
// AXI4 read master for the DMA read engine: splits a (start address, beat count)
// command into INCR bursts, one outstanding at a time, and streams R beats downstream.
module axi_read_burst_master #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int CNT_WIDTH     = 10
) (
  input  logic                     AXI_aclk,
  input  logic                     AXI_areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]     cmd_beats,
  output logic [ADDRESS_WIDTH-1:0] AXI_araddr,
  output logic [7:0]               AXI_arlen,
  output logic [2:0]               AXI_arsize,
  output logic [1:0]               AXI_arburst,
  output logic                     AXI_arvalid,
  input  logic                     AXI_arready,
  input  logic [DATA_WIDTH-1:0]    AXI_rdata,
  input  logic [1:0]               AXI_rresp,
  input  logic                     AXI_rlast,
  input  logic                     AXI_rvalid,
  output logic                     AXI_rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done,
  output logic                     error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                     state;
  logic [CNT_WIDTH-1:0]       remaining;
  logic [CNT_WIDTH-1:0]       remaining_next;
  logic [8:0]                 beat_cnt;
  logic                       err;
  logic                       in_data;
  logic                       beat;
  logic                       beat_err;
  logic [ADDRESS_WIDTH-1:0]   addr_step;

  function automatic logic [8:0] burst_of(input logic [CNT_WIDTH-1:0] rem);
    if (32'(rem) > 32'(MAX_BURST_LEN)) burst_of = 9'(MAX_BURST_LEN);
    else                               burst_of = 9'(rem);
  endfunction

  assign AXI_arsize     = 3'(SIZE);
  assign AXI_arburst    = 2'b01;
  assign cmd_ready      = (state == S_IDLE);
  assign in_data        = (state == S_DATA);
  assign AXI_rready     = in_data & out_ready;
  assign out_valid      = in_data & AXI_rvalid;
  assign out_data       = AXI_rdata;
  assign out_last       = out_valid & (remaining == CNT_WIDTH'(1));
  assign beat           = out_valid & out_ready;
  assign remaining_next = remaining - CNT_WIDTH'(1);
  assign addr_step      = ADDRESS_WIDTH'((32'(AXI_arlen) + 32'd1) * BYTES);

  // A misplaced rlast is flagged, but the burst is always closed by our own beat count.
  assign beat_err = (AXI_rresp != 2'b00)
                  | ((beat_cnt == 9'd1) & ~AXI_rlast)
                  | ((beat_cnt >  9'd1) &  AXI_rlast);

  // NOTE: every state register uses non-blocking assignment and is cleared by the
  // synchronous reset, so a reset mid-burst drops straight to IDLE with no done pulse.
  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      state       <= S_IDLE;
      AXI_arvalid <= 1'b0;
      AXI_araddr  <= '0;
      AXI_arlen   <= '0;
      remaining   <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            AXI_araddr <= cmd_addr & ALIGN_MASK;
            remaining  <= cmd_beats;
            if (cmd_beats == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b0;
            end else begin
              state       <= S_ADDR;
              AXI_arvalid <= 1'b1;
              AXI_arlen   <= 8'(burst_of(cmd_beats) - 9'd1);
            end
          end
        end
        S_ADDR: begin
          if (AXI_arready) begin
            AXI_arvalid <= 1'b0;
            beat_cnt    <= 9'(AXI_arlen) + 9'd1;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            beat_cnt  <= beat_cnt - 9'd1;
            remaining <= remaining_next;
            err       <= err | beat_err;
            if (beat_cnt == 9'd1) begin
              AXI_araddr <= AXI_araddr + addr_step;
              if (remaining_next != '0) begin
                state       <= S_ADDR;
                AXI_arvalid <= 1'b1;
                AXI_arlen   <= 8'(burst_of(remaining_next) - 9'd1);
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
                error <= err | beat_err;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          error <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
